// File: rtl/dct_macu_pipe_if.sv
// Sample/coefficient input and block-result output of dct_macu_pipe.
// The master side drives samples; the slave side is the MAC unit.
interface dct_macu_pipe_if #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 12
);
  logic              ena;
  logic              in_valid;
  logic              in_first;
  logic [DATA_W-1:0] din;
  logic [COEF_W-1:0] coef;
  logic [OUT_W-1:0]  result;
  logic              out_valid;
  logic              busy;

  modport master (
    output ena, in_valid, in_first, din, coef,
    input  result, out_valid, busy
  );

  modport slave (
    input  ena, in_valid, in_first, din, coef,
    output result, out_valid, busy
  );
endinterface

// File: rtl/dct_macu_pipe.sv
// Two-stage signed multiply-accumulate for the forward DCT: TAPS products per block,
// arithmetic right shift by SHIFT, narrowed to OUT_W. Define DCT_MACU_SAT_EN to clamp instead of wrap.
module dct_macu_pipe #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 11,
  parameter int OUT_W  = 12,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input logic              clk,
  input logic              rst,
  dct_macu_pipe_if.slave   bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

  logic signed [PROD_W-1:0] mult_res;
  logic                     p_valid;
  logic                     p_first;
  logic [CNT_W-1:0]         tap_cnt;
  logic signed [ACC_W-1:0]  acc;

  logic                     start;
  logic [CNT_W-1:0]         idx;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]         reduced;

`ifdef DCT_MACU_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;
`endif

  // A first-marked product, or any product arriving with no block open, restarts the sum.
  always_comb begin
    start    = p_first || (tap_cnt == '0);
    idx      = start ? '0 : tap_cnt;
    prod_ext = {{(ACC_W-PROD_W){mult_res[PROD_W-1]}}, mult_res};
    sum      = start ? prod_ext : acc + prod_ext;
`ifdef DCT_MACU_SAT_EN
    shifted = sum >>> SHIFT;
    if (shifted > SAT_MAX)
      reduced = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN)
      reduced = SAT_MIN[OUT_W-1:0];
    else
      reduced = shifted[OUT_W-1:0];
`else
    reduced = OUT_W'(sum >>> SHIFT);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mult_res      <= '0;
      p_valid       <= 1'b0;
      p_first       <= 1'b0;
      tap_cnt       <= '0;
      acc           <= '0;
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.ena) begin
        if (bus.in_valid) begin
          mult_res <= $signed(bus.din) * $signed(bus.coef);
          p_valid  <= 1'b1;
          p_first  <= bus.in_first;
        end else begin
          p_valid  <= 1'b0;
        end

        if (p_valid) begin
          if (idx == LAST_IDX) begin
            bus.result    <= reduced;
            bus.out_valid <= 1'b1;
            tap_cnt       <= '0;
            bus.busy      <= 1'b0;
          end else begin
            acc           <= sum;
            tap_cnt       <= idx + CNT_W'(1);
            bus.busy      <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/dct_macu_pipe.md
# dct_macu_pipe

Parametrised, pipelined signed multiply-accumulate unit for the forward-DCT datapath of the JPEG encoder (`fdct_zigzag.dct_mod`). It is the generalised successor of the fixed 8-tap `macu` used in each `dct_unit`. Each instance accepts one sample/coefficient pair per cycle and registers the product in `mult_res`. It accumulates `TAPS` products per block and emits one scaled, width-reduced `result` with a single-cycle valid pulse. Tap count, operand widths, output scaling and optional saturation are all configurable.

## Interface
Parameters:
- `DATA_W`, 12: signed sample width.
- `COEF_W`, 12: signed coefficient width.
- `TAPS`, 8: products per block. Must be ≥ 2.
- `SHIFT`, 11: arithmetic right shift applied to the final sum before output.
- `OUT_W`, 12: signed result width.
- `ACC_W`, `DATA_W+COEF_W+$clog2(TAPS)`: accumulator width. The accumulator never overflows at this width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ena` in 1: global clock enable. When low, all state is held.
- `in_valid` in 1: a sample/coefficient pair is present this cycle.
- `in_first` in 1: qualified by `in_valid`; marks the first pair of a block.
- `din` in `DATA_W`: signed sample.
- `coef` in `COEF_W`: signed coefficient.
- `result` out `OUT_W`: signed block result. Held between updates.
- `out_valid` out 1: one-cycle pulse marking a new `result`.
- `busy` out 1: high while a block is partially accumulated (`tap_cnt != 0`).

## Operation
- **Stage 1 (multiply).** An input is accepted when `ena && in_valid`. On acceptance: `mult_res <= din*coef` (full `DATA_W+COEF_W` signed), `p_valid <= 1`, `p_first <= in_first`. Otherwise `p_valid <= 0`.
- **Stage 2 (accumulate).** Operates when `ena && p_valid`. Let `start = p_first || tap_cnt==0`.
  - `sum = start ? sext(mult_res) : acc + sext(mult_res)`.
  - If `start`, the tap index is treated as 0. A `p_first` mid-block discards the partial sum and starts a new block; no output is produced for the abandoned block.
  - If the effective index equals `TAPS-1`: `result <= reduce(sum)`, `out_valid <= 1`, `tap_cnt <= 0`.
  - Otherwise: `acc <= sum`, `tap_cnt <= index+1`, `out_valid <= 0`.
- **Reduction.** `reduce(x) = (x >>> SHIFT)` truncated to the low `OUT_W` bits. The shift floors toward −∞ and applies no rounding. See Configuration for the saturating variant.
- **Gaps.** Gaps in `in_valid` are allowed anywhere in a block; a block may span any number of cycles.
- **`ena` low.** All registers hold, except `out_valid`, which is forced to 0. A pending product completes once `ena` returns high.
- **`in_first` on the final tap.** Only possible when `TAPS` would be 1, which is illegal; no special handling is required.
- **Reset.**
  - State: `result=0`, `out_valid=0`, `busy=0`, `tap_cnt=0`, `acc=0`, `mult_res=0`, `p_valid=0`, `p_first=0`.
  - Priority: reset overrides `ena`.
  - Mid-block: a reset during a block discards it with no output.

## Timing
- **Latency.** Last pair accepted at edge N → `mult_res` valid after N → `result`/`out_valid` updated at edge N+1. This is 2 cycles from input to output.
- **Throughput.** One pair per cycle sustained, giving one result per `TAPS` cycles. There is no back-pressure; the consumer must always accept `out_valid`.
- **Back-to-back blocks.** Supported with no bubble. A new block's first product may enter stage 2 in the same cycle that the previous `result` is registered.
- **Outputs.** `out_valid` is high for exactly one cycle per completed block. `busy` is registered and reflects `tap_cnt` after the edge.

## Configuration
- **`DCT_MACU_SAT_EN` defined.** `reduce()` clamps `x >>> SHIFT` to [−2^(OUT_W−1), 2^(OUT_W−1)−1] before narrowing.
- **`DCT_MACU_SAT_EN` undefined.** Plain two's-complement truncation as above. There is no extra logic and no change in latency.

## Test plan
All scenarios use default parameters.
- **Basic block.** Eight consecutive pairs `din=1024`, `coef=256`, `in_first` on the first → single `out_valid` pulse 2 cycles after the last pair; `result=1024` (0x400).
- **Negative and gapped input.** Same as the basic block but `din=-1024`, with 3-cycle `in_valid` gaps between taps → `result=-1024` (0xC00); `busy` high from the first accepted tap until the output.
- **Overflow.** Eight pairs `din=2047`, `coef=2047` → `result=0x7FF` with `DCT_MACU_SAT_EN`; `result=0xFF0` (−16) without it.
- **Back-to-back and restart.** Two back-to-back blocks of `din=1024`/`coef=256` then `din=512`/`coef=256` → pulses 8 cycles apart with results 1024 then 512. Then a restart: 5 taps, then `in_first` with 8 new taps of `din=512`/`coef=256` → only one pulse, `result=512`.
- **Enable and reset.** Drop `ena` for 4 cycles mid-block → block completes with the correct sum and `out_valid` never asserted while `ena` is low. Assert `rst` after tap 4 → all outputs 0 next cycle; the following full block gives the correct result.
